// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, 16x16 -> 32 signed.
// Retires one Booth digit per cycle over 8 BUSY cycles. Operands come in and the
// product goes out over valid/ready handshakes.
module booth_seq_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        sel_x1,
    output logic        sel_x2,
    output logic        sel_neg1,
    output logic        sel_neg2
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [17:0] scan_q, scan_d;   // {B[15], B, 1'b0}, shifted right two bits per digit
    logic [31:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [16:0] pp_mag;
    logic [31:0] pp_ext;
    logic [31:0] pp_signed;

    // Booth digit decode from the low triplet of the scan register; only active in BUSY
    always_comb begin
        sel_x1   = 1'b0;
        sel_x2   = 1'b0;
        sel_neg1 = 1'b0;
        sel_neg2 = 1'b0;
        if (state_q == StBusy) begin
            unique case (scan_q[2:0])
                3'b001, 3'b010: sel_x1   = 1'b1;
                3'b011:         sel_x2   = 1'b1;
                3'b100:         sel_neg2 = 1'b1;
                3'b101, 3'b110: sel_neg1 = 1'b1;
                default:        ;  // 000 and 111 are a zero digit
            endcase
        end
    end

    // Partial product; negation happens after sign extension so that -(2 * -32768) stays exact
    always_comb begin
        pp_mag = '0;
        if (sel_x1 || sel_neg1) begin
            pp_mag = {a_q[15], a_q};
        end else if (sel_x2 || sel_neg2) begin
            pp_mag = {a_q, 1'b0};
        end
        pp_ext    = {{15{pp_mag[16]}}, pp_mag};
        pp_signed = (sel_neg1 || sel_neg2) ? (~pp_ext + 32'd1) : pp_ext;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        scan_d  = scan_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    scan_d  = {multiplier[15], multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d  = acc_q + (pp_signed << {cnt_q, 1'b0});
                scan_d = {{2{scan_q[17]}}, scan_q[17:2]};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            scan_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            scan_q  <= scan_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign product   = acc_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult: reset, products, select trace, backpressure,
// mid-operation reset, back-to-back handshakes and a random sweep.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        sel_x1, sel_x2, sel_neg1, sel_neg2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_mult dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .sel_x1       (sel_x1),
        .sel_x2       (sel_x2),
        .sel_neg1     (sel_neg1),
        .sel_neg2     (sel_neg2)
    );

    // Offer one operand pair from IDLE, scramble the inputs after accept and wait for out_valid.
    // lat is the number of edges from the accept edge to out_valid, or -1 on timeout.
    task automatic run_op(input logic [15:0] a_v, input logic [15:0] b_v,
                          output logic [31:0] prod, output int lat);
        multiplicand = a_v;
        multiplier   = b_v;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid     = 1'b0;
        multiplicand = ~a_v;
        multiplier   = ~b_v;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        prod = product;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand = '0; multiplier = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL rst_product got=%h exp=0", product); end
        total++;
        if ({sel_x1, sel_x2, sel_neg1, sel_neg2} !== 4'b0000) begin
            bad++; $display("FAIL rst_sel got=%b exp=0000", {sel_x1, sel_x2, sel_neg1, sel_neg2});
        end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_after_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_products();
        logic [15:0] av [5];
        logic [15:0] bv [5];
        logic [31:0] ev [5];
        logic [31:0] p;
        int          lat;
        av[0] = 16'd3;    bv[0] = 16'd5;    ev[0] = 32'h0000000F;
        av[1] = 16'h8000; bv[1] = 16'h8000; ev[1] = 32'h40000000;
        av[2] = 16'h7FFF; bv[2] = 16'h8000; ev[2] = 32'hC0008000;
        av[3] = 16'h7FFF; bv[3] = 16'h7FFF; ev[3] = 32'h3FFF0001;
        av[4] = 16'hFFFF; bv[4] = 16'hFFFF; ev[4] = 32'h00000001;
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], p, lat);
            total++; if (lat != 8) begin bad++; $display("FAIL prod_latency[%0d] got=%0d exp=8", i, lat); end
            total++; if (p !== ev[i]) begin bad++; $display("FAIL prod_value[%0d] got=%h exp=%h", i, p, ev[i]); end
            drain();
        end
    endtask

    task automatic test_select_trace();
        logic [15:0] bv [2];
        logic [15:0] av [2];
        logic [31:0] ev [2];
        logic [3:0]  es [2][8];  // {x1, x2, neg1, neg2}
        logic [3:0]  got;
        bv[0] = 16'h0006; av[0] = 16'd1; ev[0] = 32'h00000006;
        bv[1] = 16'hFFFF; av[1] = 16'd7; ev[1] = 32'hFFFFFFF9;
        for (int d = 0; d < 8; d++) begin
            es[0][d] = 4'b0000;
            es[1][d] = 4'b0000;
        end
        es[0][0] = 4'b0001;
        es[0][1] = 4'b0100;
        es[1][0] = 4'b0010;
        for (int t = 0; t < 2; t++) begin
            multiplicand = av[t]; multiplier = bv[t]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int d = 0; d < 8; d++) begin
                got = {sel_x1, sel_x2, sel_neg1, sel_neg2};
                total++;
                if (got !== es[t][d]) begin
                    bad++; $display("FAIL sel_trace[%0d][%0d] got=%b exp=%b", t, d, got, es[t][d]);
                end
                @(posedge clk); #1;
            end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sel_done[%0d] got=%b exp=1", t, out_valid); end
            total++; if (product !== ev[t]) begin bad++; $display("FAIL sel_product[%0d] got=%h exp=%h", t, product, ev[t]); end
            total++;
            if ({sel_x1, sel_x2, sel_neg1, sel_neg2} !== 4'b0000) begin
                bad++; $display("FAIL sel_in_done[%0d] got=%b exp=0000", t, {sel_x1, sel_x2, sel_neg1, sel_neg2});
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        int          lat;
        run_op(16'h0100, 16'h0101, p, lat);
        total++; if (p !== 32'h00010100) begin bad++; $display("FAIL bp_product got=%h exp=00010100", p); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (product !== 32'h00010100) begin bad++; $display("FAIL bp_hold_product[%0d] got=%h exp=00010100", c, product); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", c, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p;
        int          lat;
        multiplicand = 16'd1234; multiplier = 16'd77; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL mid_rst_product got=%h exp=0", product); end
        total++;
        if ({sel_x1, sel_x2, sel_neg1, sel_neg2} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_sel got=%b exp=0000", {sel_x1, sel_x2, sel_neg1, sel_neg2});
        end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_spurious[%0d] got=%b exp=0", c, out_valid); end
        end
        run_op(16'hFFFE, 16'd9, p, lat);
        total++; if (lat != 8) begin bad++; $display("FAIL mid_rst_latency got=%0d exp=8", lat); end
        total++; if (p !== 32'hFFFFFFEE) begin bad++; $display("FAIL mid_rst_fresh got=%h exp=FFFFFFEE", p); end
        drain();
    endtask

    task automatic test_back_to_back();
        int          n_ev;
        int          ev_cyc [2];
        logic [31:0] ev_prod [2];
        n_ev = 0;
        ev_cyc[0] = -1; ev_cyc[1] = -1;
        ev_prod[0] = '0; ev_prod[1] = '0;
        multiplicand = 16'd3; multiplier = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                multiplicand = 16'd100;
                multiplier   = 16'd200;
            end
            if (c == 19) in_valid = 1'b0;
            if (out_valid) begin
                if (n_ev < 2) begin
                    ev_cyc[n_ev]  = c;
                    ev_prod[n_ev] = product;
                end
                n_ev++;
            end
        end
        out_ready = 1'b0;
        total++; if (n_ev != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n_ev); end
        total++; if (ev_cyc[0] != 8) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=8", ev_cyc[0]); end
        total++; if (ev_cyc[1] != 18) begin bad++; $display("FAIL b2b_second_cycle got=%0d exp=18", ev_cyc[1]); end
        total++; if (ev_prod[0] !== 32'h0000000F) begin bad++; $display("FAIL b2b_first_product got=%h exp=0000000F", ev_prod[0]); end
        total++; if (ev_prod[1] !== 32'h00004E20) begin bad++; $display("FAIL b2b_second_product got=%h exp=00004E20", ev_prod[1]); end
    endtask

    task automatic test_random();
        logic [15:0] a_v, b_v;
        logic [31:0] ref_v, p;
        int          lat, stall;
        for (int n = 0; n < 2000; n++) begin
            a_v = 16'($urandom);
            b_v = 16'($urandom);
            ref_v = {{16{a_v[15]}}, a_v} * {{16{b_v[15]}}, b_v};
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_spurious[%0d] got=%b exp=0", n, out_valid); end
            run_op(a_v, b_v, p, lat);
            total++; if (lat != 8) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=8", n, lat); end
            total++;
            if (p !== ref_v) begin
                bad++; $display("FAIL rand_product[%0d] a=%h b=%h got=%h exp=%h", n, a_v, b_v, p, ref_v);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                total++; if (product !== ref_v) begin bad++; $display("FAIL rand_stall[%0d] got=%h exp=%h", n, product, ref_v); end
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_select_trace();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
